// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32 constants: datapath width, major opcodes, canonical NOP
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - 2-entry synchronous FIFO; entry 0 is always the head
module fetch_fifo #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [1:0]       occ
);

  logic [WIDTH-1:0] e0;
  logic [WIDTH-1:0] e1;
  logic             pop_ok;

  assign pop_ok = pop & (occ != 2'd0);
  assign rdata  = e0;

  always_ff @(posedge clk) begin
    if (reset) begin
      occ <= 2'd0;
      e0  <= '0;
      e1  <= '0;
    end else if (flush) begin
      occ <= 2'd0;
    end else begin
      case ({push, pop_ok})
        2'b10: begin
          if (occ == 2'd0) e0 <= wdata;
          else             e1 <= wdata;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          e0  <= e1;
          occ <= occ - 2'd1;
        end
        2'b11: begin
          // occ unchanged; the new word lands behind whatever remains
          if (occ == 2'd1) begin
            e0 <= wdata;
          end else begin
            e0 <= e1;
            e1 <= wdata;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) assert (!(push && !pop_ok && occ == 2'd2));
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RV32 instruction fetch: PC, one-outstanding imem issue, redirect/drop, 2-deep buffer
module fetch_stage #(
  parameter int             XLEN     = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            id_ready,
  output logic [31:0]     if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic [6:0]      if_opcode,
  output logic [2:0]      if_funct3
);

  logic [XLEN-1:0]    pc;
  logic [XLEN-1:0]    tag_pc;
  logic               outstanding;
  logic               drop;
  logic [1:0]         occ;
  logic               pop;
  logic               push;
  logic               grant;
  logic               accept_rsp;
  logic               pending;
  logic [2:0]         occ_next;
  logic [2:0]         slots;
  logic [32+XLEN-1:0] head;

  assign pop        = if_valid & id_ready;
  assign accept_rsp = imem_rvalid & !drop;
  assign push       = accept_rsp & !redirect_valid;
  assign pending    = outstanding & !imem_rvalid;
  assign occ_next   = {1'b0, occ} - {2'b0, pop} + {2'b0, accept_rsp};
  // A word still in flight already owns a FIFO slot
  assign slots      = occ_next + {2'b0, pending};
  assign imem_req   = !reset & !redirect_valid & (slots < 3'd2);
  assign imem_addr  = pc;
  assign grant      = imem_req & imem_gnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      tag_pc      <= '0;
      outstanding <= 1'b0;
      drop        <= 1'b0;
    end else if (redirect_valid) begin
      pc <= {redirect_pc[XLEN-1:2], 2'b00};
      if (imem_rvalid) begin
        outstanding <= 1'b0;
        drop        <= 1'b0;
      end else if (outstanding) begin
        drop <= 1'b1;
      end
    end else begin
      if (grant) begin
        pc          <= pc + XLEN'(4);
        tag_pc      <= pc;
        outstanding <= 1'b1;
      end else if (imem_rvalid) begin
        outstanding <= 1'b0;
      end
      if (imem_rvalid && drop) drop <= 1'b0;
    end
  end

  fetch_fifo #(.WIDTH(32 + XLEN)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata ({imem_rdata, tag_pc}),
    .rdata (head),
    .occ   (occ)
  );

  assign if_valid  = (occ != 2'd0);
  assign if_instr  = head[32+XLEN-1:XLEN];
  assign if_pc     = head[XLEN-1:0];
  assign if_opcode = if_instr[6:0];
  assign if_funct3 = if_instr[14:12];

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed bench for fetch_stage with a bench-side variable-latency imem
module tb_fetch_stage;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        id_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [6:0]  if_opcode;
  logic [2:0]  if_funct3;

  int          checks = 0;
  int          errors = 0;
  int          lat = 1;
  int          mcnt = 0;
  int          waited;
  logic        mbusy = 1'b0;
  logic [31:0] maddr = '0;
  logic [31:0] req_addr = '0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .id_ready       (id_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_opcode      (if_opcode),
    .if_funct3      (if_funct3)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return {a[24:0], OP_IMM};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive memory outputs for the current cycle, then grant if the memory is free
  task automatic settle();
    imem_rvalid = mbusy && (mcnt == 1);
    imem_rdata  = imem_rvalid ? mem_word(maddr) : 32'h0;
    #1;
    imem_gnt = imem_req && (!mbusy || imem_rvalid);
    req_addr = imem_addr;
    #1;
  endtask

  task automatic advance();
    @(posedge clk);
    if (reset) begin
      mbusy = 1'b0;
    end else begin
      if (imem_rvalid) mbusy = 1'b0;
      else if (mbusy) mcnt--;
      if (imem_gnt) begin
        mbusy = 1'b1;
        mcnt  = lat;
        maddr = req_addr;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; id_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    advance();
    settle();
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_if_instr", if_instr, 32'h0);
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_imem_addr", imem_addr, 32'h0);
    advance();

    // latency and streaming with a 1-cycle memory
    reset = 1'b0; id_ready = 1'b1;
    settle();
    chk("c0_req", 32'(imem_req), 32'd1);
    chk("c0_addr", imem_addr, 32'h0);
    chk("c0_valid", 32'(if_valid), 32'd0);
    advance();
    settle();
    chk("c1_valid", 32'(if_valid), 32'd0);
    chk("c1_addr", imem_addr, 32'h4);
    advance();
    for (int k = 0; k < 8; k++) begin
      settle();
      chk("stream_valid", 32'(if_valid), 32'd1);
      chk("stream_pc", if_pc, 32'(4 * k));
      chk("stream_instr", if_instr, mem_word(32'(4 * k)));
      if (k == 0) begin
        chk("first_opcode", 32'(if_opcode), 32'(OP_IMM));
        chk("first_funct3", 32'(if_funct3), 32'd0);
      end
      advance();
    end

    // backpressure: two words held, request withheld, outputs stable
    id_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      settle();
      chk("stall_valid", 32'(if_valid), 32'd1);
      chk("stall_pc", if_pc, 32'h20);
      chk("stall_instr", if_instr, mem_word(32'h20));
      chk("stall_req", 32'(imem_req), 32'd0);
      advance();
    end
    id_ready = 1'b1;
    settle();
    chk("resume_pc", if_pc, 32'h20);
    chk("resume_req", 32'(imem_req), 32'd1);
    chk("resume_addr", imem_addr, 32'h28);
    advance();
    settle();
    chk("held2_pc", if_pc, 32'h24);
    advance();
    settle();
    chk("next_pc", if_pc, 32'h28);
    chk("next_valid", 32'(if_valid), 32'd1);
    advance();

    // redirect coinciding with a response
    redirect_valid = 1'b1; redirect_pc = 32'h203;
    settle();
    chk("redir5_req", 32'(imem_req), 32'd0);
    chk("redir5_pc", if_pc, 32'h2c);
    advance();
    redirect_valid = 1'b0;
    settle();
    chk("redir5_flushed", 32'(if_valid), 32'd0);
    chk("redir5_req_next", 32'(imem_req), 32'd1);
    chk("redir5_addr", imem_addr, 32'h200);
    advance();
    settle();
    chk("redir5_bubble", 32'(if_valid), 32'd0);
    advance();
    settle();
    chk("redir5_tgt_valid", 32'(if_valid), 32'd1);
    chk("redir5_tgt_pc", if_pc, 32'h200);
    chk("redir5_tgt_instr", if_instr, mem_word(32'h200));
    advance();

    // fill to two entries, then reset mid-stream
    id_ready = 1'b0;
    settle();
    chk("fill_pc", if_pc, 32'h204);
    chk("fill_req", 32'(imem_req), 32'd0);
    advance();
    reset = 1'b1;
    settle();
    chk("midrst_req", 32'(imem_req), 32'd0);
    chk("midrst_full_pc", if_pc, 32'h204);
    advance();
    reset = 1'b0; id_ready = 1'b1; lat = 3;
    settle();
    chk("midrst_valid", 32'(if_valid), 32'd0);
    chk("midrst_addr", imem_addr, 32'h0);
    chk("midrst_instr", if_instr, 32'h0);
    chk("midrst_req", 32'(imem_req), 32'd1);
    advance();

    // redirect with a request in flight, 3-cycle memory
    settle(); advance();
    settle(); advance();
    settle();
    chk("slow_first_pending", 32'(if_valid), 32'd0);
    advance();
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    settle();
    chk("redir4_head_valid", 32'(if_valid), 32'd1);
    chk("redir4_head_pc", if_pc, 32'h0);
    chk("redir4_req", 32'(imem_req), 32'd0);
    advance();
    redirect_valid = 1'b0;
    settle();
    chk("redir4_empty", 32'(if_valid), 32'd0);
    chk("redir4_addr", imem_addr, 32'h100);
    advance();
    settle();
    chk("redir4_stale_req", 32'(imem_req), 32'd1);
    advance();
    settle();
    chk("redir4_stale_dropped", 32'(if_valid), 32'd0);
    advance();
    waited = 0;
    settle();
    while (!if_valid && waited < 10) begin
      advance(); settle(); waited++;
    end
    chk("redir4_wait", 32'(waited), 32'd2);
    chk("redir4_tgt_pc", if_pc, 32'h100);
    chk("redir4_tgt_instr", if_instr, mem_word(32'h100));

    // unaligned redirect near the top of the address space; pc wraps to 0
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    settle();
    chk("wrap_redir_req", 32'(imem_req), 32'd0);
    advance();
    redirect_valid = 1'b0;
    settle();
    chk("wrap_aligned_addr", imem_addr, 32'hFFFF_FFFC);
    chk("wrap_empty", 32'(if_valid), 32'd0);
    advance();
    settle();
    chk("wrap_issue", 32'(imem_req), 32'd1);
    advance();
    settle();
    chk("wrap_addr", imem_addr, 32'h0);
    advance();
    waited = 0;
    settle();
    while (!if_valid && waited < 10) begin
      advance(); settle(); waited++;
    end
    chk("wrap_wait", 32'(waited), 32'd2);
    chk("wrap_tgt_pc", if_pc, 32'hFFFF_FFFC);
    chk("wrap_tgt_instr", if_instr, mem_word(32'hFFFF_FFFC));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
